// File: rtl/control_unit_pkg.sv
// Shared encodings for the multicycle control path: FSM states, opcode/funct
// constants, ALU operation codes and mux select values.
package control_unit_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [5:0] ALU_ADD = 6'b000010;
  localparam logic [5:0] ALU_SUB = 6'b000110;
  localparam logic [5:0] ALU_AND = 6'b000000;
  localparam logic [5:0] ALU_OR  = 6'b000001;
  localparam logic [5:0] ALU_SLT = 6'b000111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/control_unit_alu_decoder.sv
// R-type funct decode: selects the ALU operation and flags unsupported functs
// (which fall back to ADD so the datapath still sees a defined op).
module alu_decoder
  import control_unit_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [5:0] alu_control_o,
  output logic       funct_illegal_o
);

  always_comb begin
    alu_control_o   = ALU_ADD;
    funct_illegal_o = 1'b0;
    case (funct_i)
      FN_ADD:  alu_control_o = ALU_ADD;
      FN_SUB:  alu_control_o = ALU_SUB;
      FN_AND:  alu_control_o = ALU_AND;
      FN_OR:   alu_control_o = ALU_OR;
      FN_SLT:  alu_control_o = ALU_SLT;
      default: funct_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle MIPS-style control FSM. Outputs are a pure decode of the state
// register, with mem_ready/zero gating the PC and IR enables.
module control_unit
  import control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [5:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_instr
);

  state_e     state_q, state_d;
  logic [5:0] dec_alu_control;
  logic       dec_funct_illegal;

  alu_decoder u_alu_decoder (
    .funct_i        (funct),
    .alu_control_o  (dec_alu_control),
    .funct_illegal_o(dec_funct_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    alu_control   = 6'b000000;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_src        = PCSRC_ALU;
    pc_en         = 1'b0;
    iord          = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_control = ALU_ADD;
        alu_src_b   = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is computed here so BRANCH only needs the compare.
        alu_control = ALU_ADD;
        alu_src_b   = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_instr = 1'b1;
            state_d       = S_FETCH;
          end
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        alu_control = ALU_ADD;
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_IMM;
        if (state_q == S_ADDIEX)   state_d = S_ADDIWB;
        else if (opcode == OP_SW)  state_d = S_MEMWRITE;
        else                       state_d = S_MEMREAD;
      end
      S_MEMREAD: begin
        iord = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = dec_alu_control;
        if (dec_funct_illegal) begin
          illegal_instr = 1'b1;
          state_d       = S_FETCH;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_BRANCH: begin
        alu_control = ALU_SUB;
        alu_src_a   = 1'b1;
        pc_src      = PCSRC_ALUOUT;
        pc_en       = zero;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = PCSRC_JUMP;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset holds the FETCH decode on the muxes but no strobe may fire.
    if (!rst_n) begin
      pc_en         = 1'b0;
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Cycle-by-cycle check of the control outputs against per-instruction
// expected sequences derived from the instruction-level behaviour.
module tb_control_unit;

  logic       clk, rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic [5:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal_instr;

  int total = 0;
  int bad   = 0;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alu_control(alu_control), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en), .iord(iord),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal_instr(illegal_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector: {alu_control, src_a, src_b, pc_src, pc_en, iord, mem_write,
  //                 ir_write, reg_dst, mem_to_reg, reg_write, illegal_instr}
  function automatic logic [18:0] mk(logic [5:0] ac, logic sa, logic [1:0] sb, logic [1:0] ps,
                                     logic pe, logic io, logic mw, logic irw, logic rd,
                                     logic m2r, logic rw, logic ill);
    return {ac, sa, sb, ps, pe, io, mw, irw, rd, m2r, rw, ill};
  endfunction

  function automatic logic [18:0] observed();
    return {alu_control, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_write,
            ir_write, reg_dst, mem_to_reg, reg_write, illegal_instr};
  endfunction

  localparam logic [5:0] ADD = 6'b000010, SUB = 6'b000110;

  // Instruction-level ALU semantics of the supported functs; bit 6 = unsupported.
  function automatic logic [6:0] funct_op(logic [5:0] fn);
    case (fn)
      6'b100000: return {1'b0, 6'b000010};
      6'b100010: return {1'b0, 6'b000110};
      6'b100100: return {1'b0, 6'b000000};
      6'b100101: return {1'b0, 6'b000001};
      6'b101010: return {1'b0, 6'b000111};
      default:   return {1'b1, 6'b000010};
    endcase
  endfunction

  function automatic bit op_legal(logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  function automatic logic [18:0] e_fetch(logic r);
    return mk(ADD, 1'b0, 2'b01, 2'b00, r, 1'b0, 1'b0, r, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [18:0] e_reset();
    return mk(ADD, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [18:0] e_rd_wb(logic rd, logic m2r);
    return mk(6'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, rd, m2r, 1'b1, 1'b0);
  endfunction

  function automatic logic [18:0] e_mem(logic w);
    return mk(6'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, w, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input logic [18:0] exp, input string tag);
    logic [18:0] obs;
    obs = observed();
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive, check, then let the rising edge pass.
  task automatic step(input logic rdy, input logic z, input logic [18:0] exp, input string tag);
    mem_ready = rdy;
    zero      = z;
    #1;
    check(exp, tag);
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int sf, input int sm);
    logic [6:0] fo;
    opcode = op;
    funct  = fn;
    fo     = funct_op(fn);
    repeat (sf) step(1'b0, rb(), e_fetch(1'b0), "fetch_stall");
    step(1'b1, rb(), e_fetch(1'b1), "fetch");
    step(rb(), rb(), mk(ADD, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                        !op_legal(op)), "decode");
    case (op)
      6'b100011, 6'b101011, 6'b001000: begin
        step(rb(), rb(), mk(ADD, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0), "addr_calc");
        if (op == 6'b001000) begin
          step(rb(), rb(), e_rd_wb(1'b0, 1'b0), "addi_wb");
        end else begin
          repeat (sm) step(1'b0, rb(), e_mem(op == 6'b101011), "mem_stall");
          step(1'b1, rb(), e_mem(op == 6'b101011), "mem_access");
          if (op == 6'b100011) step(rb(), rb(), e_rd_wb(1'b0, 1'b1), "lw_wb");
        end
      end
      6'b000000: begin
        step(rb(), rb(), mk(fo[5:0], 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, fo[6]), "execute");
        if (!fo[6]) step(rb(), rb(), e_rd_wb(1'b1, 1'b0), "alu_wb");
      end
      6'b000100: step(rb(), z, mk(SUB, 1'b1, 2'b00, 2'b01, z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b0), "branch");
      6'b000010: step(rb(), rb(), mk(6'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                     1'b0, 1'b0, 1'b0), "jump");
      default: ;
    endcase
  endtask

  initial begin
    logic [5:0] legal_fn [5];
    logic [5:0] op, fn;
    legal_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    #1 check(e_reset(), "reset_state");
    mem_ready = 1'b1;
    #1 check(e_reset(), "reset_strobes_ready");
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed scenarios
    run_instr(6'b100011, 6'b000000, 1'b0, 0, 0);   // lw, 5 cycles
    run_instr(6'b101011, 6'b000000, 1'b0, 0, 3);   // sw, 3 stalls in MEMWRITE
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);   // beq taken
    run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);   // beq not taken
    run_instr(6'b000000, 6'b100010, 1'b0, 0, 0);   // R-type SUB
    run_instr(6'b000000, 6'b111111, 1'b0, 0, 0);   // bad funct
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);   // bad opcode
    run_instr(6'b001000, 6'b000000, 1'b0, 2, 0);   // addi with fetch stalls
    run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);   // j

    // Reset in the middle of a MEMREAD stall
    opcode = 6'b100011;
    step(1'b1, 1'b0, e_fetch(1'b1), "rst_seq_fetch");
    step(1'b0, 1'b0, mk(ADD, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                        1'b0), "rst_seq_decode");
    step(1'b0, 1'b0, mk(ADD, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                        1'b0), "rst_seq_memadr");
    step(1'b0, 1'b0, e_mem(1'b0), "rst_seq_memread_stall");
    mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check(e_reset(), "rst_async_fetch");
    mem_ready = 1'b1;
    @(posedge clk);
    #1 check(e_reset(), "rst_held_strobes");
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);   // first edge out of reset is FETCH

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 6))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b001000;
        5: op = 6'b000010;
        default: begin
          op = 6'($urandom);
          while (op_legal(op)) op = 6'($urandom);
        end
      endcase
      if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
      else                           fn = legal_fn[$urandom_range(0, 4)];
      run_instr(op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    step(1'b0, 1'b0, e_fetch(1'b0), "final_fetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: none; all encodings come from the shared package.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  6  instruction bits [31:26]; sampled from the instruction register.
REQ-005 funct  input  6  instruction bits [5:0]; sampled from the instruction register.
REQ-006 zero  input  1  ALU zero flag (src1 == src2).
REQ-007 mem_ready  input  1  memory handshake; 1 = the current read or write completes this cycle.
REQ-008 alu_control  output  6  ALU operation code; package values ADD=6'b000010, SUB=6'b000110, AND=6'b000000, OR=6'b000001, SLT=6'b000111.
REQ-009 alu_src_a  output  1  0 = PC, 1 = register A.
REQ-010 alu_src_b  output  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
REQ-011 pc_src  output  2  00 = ALU result, 01 = ALU output register, 10 = jump target.
REQ-012 pc_en  output  1  PC write enable.
REQ-013 iord  output  1  memory address select; 0 = PC, 1 = ALU output register.
REQ-014 mem_write  output  1  memory write strobe.
REQ-015 ir_write  output  1  instruction register load.
REQ-016 reg_dst  output  1  destination register; 0 = rt, 1 = rd.
REQ-017 mem_to_reg  output  1  write-back source; 0 = ALU output register, 1 = memory data.
REQ-018 reg_write  output  1  register file write enable.
REQ-019 illegal_instr  output  1  one-cycle pulse flagging an unsupported opcode or funct.

Function
REQ-020 The block SHALL be a multicycle FSM with these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-021 Outputs SHALL be decoded combinationally from the state register; pc_en may also depend on zero and mem_ready. Any output not named for a state SHALL be 0.
REQ-022 FETCH SHALL drive iord=0, alu_src_a=0, alu_src_b=01, alu_control=ADD and pc_src=00. It SHALL assert ir_write and pc_en only when mem_ready=1, and SHALL remain in FETCH while mem_ready=0.
REQ-023 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_control=ADD (branch-target precompute). Next state by opcode:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 (R-type) -> EXECUTE
- 000100 (beq) -> BRANCH
- 001000 (addi) -> ADDIEX
- 000010 (j) -> JUMP
- any other opcode -> FETCH, with illegal_instr=1
REQ-024 MEMADR and ADDIEX SHALL drive alu_src_a=1, alu_src_b=10 and alu_control=ADD. MEMADR goes to MEMREAD for lw and to MEMWRITE for sw; ADDIEX goes to ADDIWB.
REQ-025 MEMREAD SHALL drive iord=1 and hold until mem_ready=1, then go to MEMWB.
REQ-026 MEMWRITE SHALL drive iord=1 and mem_write=1, and hold until mem_ready=1, then go to FETCH.
REQ-027 MEMWB SHALL drive reg_dst=0, mem_to_reg=1 and reg_write=1. ADDIWB SHALL drive reg_dst=0, mem_to_reg=0 and reg_write=1. ALUWB SHALL drive reg_dst=1, mem_to_reg=0 and reg_write=1. Each then goes to FETCH.
REQ-028 EXECUTE SHALL drive alu_src_a=1 and alu_src_b=00, with alu_control chosen by funct:
- 100000 -> ADD
- 100010 -> SUB
- 100100 -> AND
- 100101 -> OR
- 101010 -> SLT
- any other funct -> ADD, illegal_instr=1, reg_write suppressed, next state FETCH instead of ALUWB
REQ-029 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_control=SUB and pc_src=01, set pc_en=zero, then go to FETCH.
REQ-030 JUMP SHALL drive pc_src=10 and pc_en=1, then go to FETCH.
REQ-031 Latency from FETCH entry back to FETCH with mem_ready held at 1 SHALL be:
- lw 5 cycles
- sw 4 cycles
- R-type 4 cycles
- addi 4 cycles
- beq 3 cycles
- j 3 cycles
Each stall cycle (mem_ready=0) SHALL add exactly one cycle.
REQ-032 An unreachable state encoding SHALL transition to FETCH on the next edge.

Reset
REQ-033 rst_n=0 SHALL immediately force the state to FETCH regardless of clk, including mid-instruction or mid-stall.
REQ-034 While rst_n=0, pc_en, ir_write, mem_write, reg_write and illegal_instr SHALL all be 0, overriding the FETCH decode.
REQ-035 The first rising edge after rst_n deasserts SHALL be evaluated as FETCH.

Structure
REQ-036 A shared package SHALL hold the state enum, the opcode/funct constants and the alu_control codes; the datapath and the ALU SHALL import the same package.
REQ-037 One sub-module, alu_decoder, SHALL map funct to alu_control and the funct-illegal flag.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
- lw (opcode 100011), mem_ready=1 throughout -> 5 cycles; reg_write=1 with mem_to_reg=1 only in cycle 5.
- sw with mem_ready=0 for 3 cycles in MEMWRITE -> mem_write high for 4 cycles; returns to FETCH in cycle 8.
- beq with zero=1 -> pc_en=1 with pc_src=01 in cycle 3; repeat with zero=0 -> pc_en=0.
- R-type with funct 100010 -> alu_control=6'b000110 in EXECUTE; funct 111111 -> illegal_instr pulse and no reg_write.
- opcode 111111 -> illegal_instr=1 in DECODE; next state FETCH.
- rst_n asserted mid-stall in MEMREAD -> FETCH immediately; all strobes 0 until release.
